sha256_msg_padder: RTL and testbench

SHA256_MSG_PADDER -- requirements
Module: sha256_msg_padder

---
 rtl/sha256_msg_padder.sv | 120 ++++++++++++
 tb/tb_sha256_msg_padder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: streams a MSG_WORDS-word message from upstream
// and appends the 0x80 marker, zero fill and 64-bit bit length. The output
// is a sequence of 32-bit schedule words, delivered with a valid/ready handshake.
module sha256_msg_padder #(
  parameter int unsigned MSG_WORDS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        in_rq,
  input  logic        in_rdy,
  input  logic [31:0] in_data,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_data,
  output logic        w_blk_last,
  output logic        w_last,
  output logic        done
);

  localparam int unsigned TOTAL = 16 * ((MSG_WORDS + 3 + 15) / 16);
  // Six bits covers every message up to 61 words; 62 and 63 pad to 80 words,
  // so the counter widens only in that case.
  localparam int unsigned CW = (TOTAL > 64) ? 7 : 6;
  localparam logic [CW-1:0] LAST_K   = CW'(TOTAL - 1);
  localparam logic [CW-1:0] MSG_K    = CW'(MSG_WORDS);
  localparam logic [31:0]   LEN_WORD = 32'(MSG_WORDS * 32);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    OUT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [31:0]     word_q, word_d;
  logic            done_q, done_d;

  // Padding word for index k, used once k is past the message words.
  function automatic logic [31:0] pad_word(input logic [CW-1:0] k);
    if (k == MSG_K) begin
      return 32'h8000_0000;
    end else if (k == LAST_K) begin
      return LEN_WORD;
    end else begin
      return '0;
    end
  endfunction

  // State, word counter, output word register and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; abort overrides start and both handshakes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    done_d  = 1'b0;
    cnt_inc = cnt_q + CW'(1);
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_d   = '0;
            state_d = REQ;
          end
        end
        REQ: begin
          if (in_rdy) begin
            word_d  = in_data;
            state_d = OUT;
          end
        end
        OUT: begin
          if (w_ready) begin
            cnt_d = cnt_inc;
            if (cnt_q == LAST_K) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else if (cnt_inc < MSG_K) begin
              state_d = REQ;
            end else begin
              // Padding needs no upstream data: load it on the same edge
              // so padding words stream one per cycle.
              word_d = pad_word(cnt_inc);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    in_rq      = (state_q == REQ);
    w_valid    = (state_q == OUT);
    w_data     = word_q;
    w_blk_last = w_valid && (cnt_q[3:0] == 4'hF);
    w_last     = w_valid && (cnt_q == LAST_K);
    done       = done_q;
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: three instances (20, 8 and 14 words)
// driven in turn, each output word compared against the padding rule.
module tb_sha256_msg_padder;

  logic        clk;
  logic        rst_n;
  logic        start      [3];
  logic        abort_s    [3];
  logic        in_rdy     [3];
  logic        w_ready    [3];
  logic [31:0] in_data    [3];
  logic        in_rq      [3];
  logic        w_valid    [3];
  logic [31:0] w_data     [3];
  logic        w_blk_last [3];
  logic        w_last     [3];
  logic        done       [3];

  int n_tests = 0;
  int n_fail  = 0;

  sha256_msg_padder #(.MSG_WORDS(20)) u_dut20 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort_s[0]),
    .in_rq(in_rq[0]), .in_rdy(in_rdy[0]), .in_data(in_data[0]),
    .w_valid(w_valid[0]), .w_ready(w_ready[0]), .w_data(w_data[0]),
    .w_blk_last(w_blk_last[0]), .w_last(w_last[0]), .done(done[0])
  );

  sha256_msg_padder #(.MSG_WORDS(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort_s[1]),
    .in_rq(in_rq[1]), .in_rdy(in_rdy[1]), .in_data(in_data[1]),
    .w_valid(w_valid[1]), .w_ready(w_ready[1]), .w_data(w_data[1]),
    .w_blk_last(w_blk_last[1]), .w_last(w_last[1]), .done(done[1])
  );

  sha256_msg_padder #(.MSG_WORDS(14)) u_dut14 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort_s[2]),
    .in_rq(in_rq[2]), .in_rdy(in_rdy[2]), .in_data(in_data[2]),
    .w_valid(w_valid[2]), .w_ready(w_ready[2]), .w_data(w_data[2]),
    .w_blk_last(w_blk_last[2]), .w_last(w_last[2]), .done(done[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Expected padded word k for an mw-word message carrying data 1..mw.
  function automatic logic [31:0] exp_word(input int mw, input int k);
    int total;
    total = 16 * ((mw + 18) / 16);
    if (k < mw)              return 32'(k + 1);
    else if (k == mw)        return 32'h8000_0000;
    else if (k == total - 1) return 32'(mw * 32);
    else                     return 32'h0;
  endfunction

  task automatic check_quiet(input int d, input string tag);
    check({tag, " in_rq"},      32'(in_rq[d]),      32'h0);
    check({tag, " w_valid"},    32'(w_valid[d]),    32'h0);
    check({tag, " w_data"},     w_data[d],          32'h0);
    check({tag, " w_blk_last"}, 32'(w_blk_last[d]), 32'h0);
    check({tag, " w_last"},     32'(w_last[d]),     32'h0);
    check({tag, " done"},       32'(done[d]),       32'h0);
  endtask

  // Runs one message on instance d. Called and returns at a falling edge.
  // stall_a/stall_b: word index held 5 cycles; abort_k/reset_k: index at
  // which to abort (with w_ready) or pull reset; -1 disables each.
  task automatic run_msg(input int d, input int mw, input int rdy_dly,
                         input int stall_a, input int stall_b,
                         input int abort_k, input int reset_k);
    int total, k, wait_c, stall_c, budget;
    bit fetched, finished, aborting;
    total = 16 * ((mw + 18) / 16);
    k = 0; wait_c = 0; stall_c = 0; budget = 0;
    fetched = 0; finished = 0; aborting = 0;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    while (!finished) begin
      if (budget >= 3000) begin
        check($sformatf("timeout d=%0d k=%0d", d, k), 32'h0, 32'h1);
        finished = 1;
      end else begin
        budget++;
        in_rdy[d]  = 1'b0;
        w_ready[d] = 1'b0;
        check($sformatf("done_early k=%0d", k), 32'(done[d]), 32'h0);
        check($sformatf("rq_and_valid k=%0d", k), 32'(in_rq[d] & w_valid[d]), 32'h0);
        if (fetched) begin
          check($sformatf("rq_drop k=%0d", k), 32'(in_rq[d]), 32'h0);
          fetched = 0;
        end
        if (in_rq[d]) begin
          if (wait_c == rdy_dly) begin
            in_rdy[d]  = 1'b1;
            in_data[d] = 32'(k + 1);
            wait_c     = 0;
            fetched    = 1;
          end else begin
            in_data[d] = 32'hDEAD_BEEF;
            wait_c++;
          end
        end else if (w_valid[d]) begin
          check($sformatf("w_data d=%0d k=%0d", d, k), w_data[d], exp_word(mw, k));
          check($sformatf("w_blk_last d=%0d k=%0d", d, k), 32'(w_blk_last[d]),
                32'((k % 16) == 15));
          check($sformatf("w_last d=%0d k=%0d", d, k), 32'(w_last[d]),
                32'(k == total - 1));
          if (k == reset_k) begin
            rst_n = 1'b0;
            #1;
            check_quiet(d, "reset_mid");
            finished = 1;
          end else if ((k == stall_a || k == stall_b) && stall_c < 5) begin
            stall_c++;
          end else begin
            w_ready[d] = 1'b1;
            stall_c    = 0;
            if (k == abort_k) begin
              abort_s[d] = 1'b1;
              aborting   = 1;
            end
            k++;
          end
        end else begin
          check($sformatf("progress d=%0d k=%0d", d, k), 32'(w_valid[d]), 32'h1);
          finished = 1;
        end
        if (!finished) begin
          @(negedge clk);
          if (aborting) begin
            abort_s[d] = 1'b0;
            w_ready[d] = 1'b0;
            check("abort w_valid", 32'(w_valid[d]), 32'h0);
            check("abort in_rq",   32'(in_rq[d]),   32'h0);
            check("abort done",    32'(done[d]),    32'h0);
            @(negedge clk);
            check("abort done_late", 32'(done[d]), 32'h0);
            finished = 1;
          end else if (k == total) begin
            w_ready[d] = 1'b0;
            check($sformatf("done_pulse d=%0d", d), 32'(done[d]), 32'h1);
            check("end w_valid", 32'(w_valid[d]), 32'h0);
            @(negedge clk);
            check("done_one_cycle", 32'(done[d]), 32'h0);
            finished = 1;
          end
        end
      end
    end
    in_rdy[d]  = 1'b0;
    w_ready[d] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; abort_s[i] = 1'b0; in_rdy[i] = 1'b0;
      w_ready[i] = 1'b0; in_data[i] = 32'h0;
    end
    #1;
    check_quiet(0, "reset_init");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Stray handshakes while idle must not move the block.
    in_rdy[0] = 1'b1; w_ready[0] = 1'b1; in_data[0] = 32'h1234_5678;
    repeat (2) @(negedge clk);
    check_quiet(0, "idle_stray");
    in_rdy[0] = 1'b0; w_ready[0] = 1'b0;

    run_msg(0, 20, 0, -1, -1, -1, -1);  // basic 80-byte header
    run_msg(1, 8,  0, -1, -1, -1, -1);  // sha256d second pass
    run_msg(0, 20, 0,  3, 21, -1, -1);  // core backpressure
    run_msg(0, 20, 3, -1, -1, -1, -1);  // slow upstream
    run_msg(2, 14, 0, -1, -1, -1, -1);  // length spills into next block
    run_msg(0, 20, 0, -1, -1, 10, -1);  // abort with w_ready
    run_msg(0, 20, 0, -1, -1, -1, -1);  // clean run after abort
    run_msg(0, 20, 0, -1, -1, -1, 25);  // reset mid-message

    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet(0, "post_reset_idle");
    run_msg(0, 20, 0, -1, -1, -1, -1);  // clean run after reset

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
